// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Registered, parametrised ALU with a valid/ready request handshake, an
//   accumulator operand, a selectable overflow policy and a multi-cycle
//   signed shift-add multiplier. Result and flags are registered and held
//   until the next operation completes.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 2)
//   SAT_MODE  overflow policy for ADD/SUB/MUL: 0 = result 0, 1 = saturate
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   request handshake; o_ready is high only in IDLE
//   i_op                opcode (0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR,
//                       6 MAX, 7 EQU, 8 MUL, 9-15 reserved)
//   i_use_acc           1: operand A is the accumulator, 0: operand A is i_a
//   i_a, i_b            signed operands
//   o_valid             one-cycle pulse when result/flags were just updated
//   o_result, o_*       registered result and flags
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH    = 4,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic             i_use_acc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_max,
    output logic             o_equ,
    output logic             o_err
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MAX = 4'd6;
    localparam logic [3:0] OP_EQU = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // State
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [W2-1:0]    prod_q;
    logic [W2-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, ovf_q, zero_q, neg_q, max_q, equ_q, err_q;

    // Datapath
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   add_u, sub_u, sum_s, diff_s;
    logic             accept, mul_last, complete;
    logic [W2-1:0]    addend, prod_nxt;

    logic [WIDTH-1:0] raw_res, fin_res;
    logic             raw_carry, raw_ovf, raw_tneg, raw_max, raw_equ, raw_err;

    assign o_ready = (state_q == ST_IDLE);
    assign accept  = i_valid && o_ready;
    assign op_a    = i_use_acc ? acc_q : i_a;

    // Unsigned (W+1)-bit sums give carry-out; sign-extended sums give the
    // true sign of the unbounded result for overflow and saturation.
    assign add_u  = {1'b0, op_a} + {1'b0, i_b};
    assign sub_u  = {1'b0, op_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign sum_s  = {op_a[WIDTH-1], op_a} + {i_b[WIDTH-1], i_b};
    assign diff_s = {op_a[WIDTH-1], op_a} - {i_b[WIDTH-1], i_b};

    // Signed shift-add multiply: the MSB of the multiplier carries weight
    // -2^(WIDTH-1), so the final partial product is subtracted.
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
    assign addend   = mplier_q[0] ? mcand_q : '0;
    assign prod_nxt = mul_last ? (prod_q - addend) : (prod_q + addend);

    assign complete = (accept && (i_op != OP_MUL)) || ((state_q == ST_MUL) && mul_last);

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        raw_res   = '0;
        raw_carry = 1'b0;
        raw_ovf   = 1'b0;
        raw_tneg  = 1'b0;
        raw_max   = 1'b0;
        raw_equ   = 1'b0;
        raw_err   = 1'b0;
        if (state_q == ST_MUL) begin
            raw_res  = prod_nxt[WIDTH-1:0];
            raw_ovf  = (prod_nxt[W2-1:WIDTH-1] != {(WIDTH+1){prod_nxt[W2-1]}});
            raw_tneg = prod_nxt[W2-1];
        end else begin
            case (i_op)
                OP_ADD: begin
                    raw_res   = add_u[WIDTH-1:0];
                    raw_carry = add_u[WIDTH];
                    raw_ovf   = sum_s[WIDTH] ^ sum_s[WIDTH-1];
                    raw_tneg  = sum_s[WIDTH];
                end
                OP_SUB: begin
                    raw_res   = sub_u[WIDTH-1:0];
                    raw_carry = sub_u[WIDTH];
                    raw_ovf   = diff_s[WIDTH] ^ diff_s[WIDTH-1];
                    raw_tneg  = diff_s[WIDTH];
                end
                OP_NOT: raw_res = ~op_a;
                OP_AND: raw_res = op_a & i_b;
                OP_OR:  raw_res = op_a | i_b;
                OP_XOR: raw_res = op_a ^ i_b;
                OP_MAX: begin
                    raw_max = ($signed(op_a) > $signed(i_b));
                    raw_res = raw_max ? op_a : i_b;
                end
                OP_EQU: begin
                    raw_equ = (op_a == i_b);
                    raw_res = WIDTH'(raw_equ);
                end
                OP_MUL: raw_res = '0;  // completes later from the MUL state
                default: raw_err = 1'b1;
            endcase
        end

        fin_res = raw_res;
        if (raw_ovf) begin
            fin_res = SAT_MODE ? (raw_tneg ? SMIN : SMAX) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && (i_op == OP_MUL)) state_d = ST_MUL;
            ST_MUL:  if (mul_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            max_q    <= 1'b0;
            equ_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= complete;

            if (complete) begin
                result_q <= fin_res;
                acc_q    <= fin_res;
                carry_q  <= raw_carry;
                ovf_q    <= raw_ovf;
                zero_q   <= (fin_res == '0);
                neg_q    <= fin_res[WIDTH-1];
                max_q    <= raw_max;
                equ_q    <= raw_equ;
                err_q    <= raw_err;
            end

            if ((state_q == ST_IDLE) && accept && (i_op == OP_MUL)) begin
                prod_q   <= '0;
                mcand_q  <= {{WIDTH{op_a[WIDTH-1]}}, op_a};
                mplier_q <= i_b;
                cnt_q    <= '0;
            end else if (state_q == ST_MUL) begin
                prod_q   <= prod_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;
    assign o_neg      = neg_q;
    assign o_max      = max_q;
    assign o_equ      = equ_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq at WIDTH=4. Two instances share the
//   stimulus: dut0 with SAT_MODE=0 and dut1 with SAT_MODE=1. Directed table
//   vectors, hand-written handshake/reset sequences and a randomized run
//   compared against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         i_rst, i_valid, i_use_acc;
    logic [3:0]   i_op;
    logic [W-1:0] i_a, i_b;

    logic         d0_ready, d0_valid, d0_carry, d0_ovf, d0_zero, d0_neg, d0_max, d0_equ, d0_err;
    logic [W-1:0] d0_result;
    logic         d1_ready, d1_valid, d1_carry, d1_ovf, d1_zero, d1_neg, d1_max, d1_equ, d1_err;
    logic [W-1:0] d1_result;

    alu_seq #(.WIDTH(W), .SAT_MODE(1'b0)) dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(d0_ready),
        .i_op(i_op), .i_use_acc(i_use_acc), .i_a(i_a), .i_b(i_b),
        .o_valid(d0_valid), .o_result(d0_result), .o_carry(d0_carry),
        .o_overflow(d0_ovf), .o_zero(d0_zero), .o_neg(d0_neg),
        .o_max(d0_max), .o_equ(d0_equ), .o_err(d0_err)
    );

    alu_seq #(.WIDTH(W), .SAT_MODE(1'b1)) dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(d1_ready),
        .i_op(i_op), .i_use_acc(i_use_acc), .i_a(i_a), .i_b(i_b),
        .o_valid(d1_valid), .o_result(d1_result), .o_carry(d1_carry),
        .o_overflow(d1_ovf), .o_zero(d1_zero), .o_neg(d1_neg),
        .o_max(d1_max), .o_equ(d1_equ), .o_err(d1_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flags packed as {carry, overflow, zero, neg, max, equ, err}
    function automatic logic [6:0] flags0();
        return {d0_carry, d0_ovf, d0_zero, d0_neg, d0_max, d0_equ, d0_err};
    endfunction
    function automatic logic [6:0] flags1();
        return {d1_carry, d1_ovf, d1_zero, d1_neg, d1_max, d1_equ, d1_err};
    endfunction

    typedef struct {
        logic [W-1:0] res;
        logic [6:0]   flags;
    } exp_t;

    // Reference model: works on the true integer value of each operation
    // and derives the registered result from it.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input bit sat);
        exp_t e;
        int sa, sb, ua, ub, t, hi, lo;
        bit arith, c, o, m, q, er;
        sa = $signed(a); sb = $signed(b);
        ua = a;          ub = b;
        hi = (1 << (W - 1)) - 1;
        lo = -(1 << (W - 1));
        arith = 0; c = 0; o = 0; m = 0; q = 0; er = 0; t = 0;
        e.res = '0;
        case (op)
            4'd0: begin t = sa + sb; arith = 1; c = (ua + ub) >= (1 << W); end
            4'd1: begin t = sa - sb; arith = 1; c = (ua >= ub); end
            4'd2: e.res = ~a;
            4'd3: e.res = a & b;
            4'd4: e.res = a | b;
            4'd5: e.res = a ^ b;
            4'd6: begin m = (sa > sb); e.res = m ? a : b; end
            4'd7: begin q = (a == b); e.res = q ? W'(1) : W'(0); end
            4'd8: begin t = sa * sb; arith = 1; end
            default: er = 1;
        endcase
        if (arith) begin
            if (t > hi || t < lo) begin
                o = 1;
                e.res = sat ? ((t < 0) ? W'(lo) : W'(hi)) : W'(0);
            end else begin
                e.res = W'(t);
            end
        end
        e.flags = {c, o, (e.res == '0), e.res[W-1], m, q, er};
        return e;
    endfunction

    logic [W-1:0] acc0, acc1;

    task automatic do_reset();
        i_rst = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        acc0 = '0; acc1 = '0;
    endtask

    // Issue one operation from a negedge with the DUTs idle; returns at the
    // negedge of the completion cycle. With poke set, an ADD request is held
    // on i_valid through the MUL busy cycles.
    task automatic exec(input logic [3:0] op, input logic use_acc,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                        output exp_t e0, output exp_t e1);
        e0 = model(op, use_acc ? acc0 : a, b, 1'b0);
        e1 = model(op, use_acc ? acc1 : a, b, 1'b1);
        i_op = op; i_use_acc = use_acc; i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (op == 4'd8) begin
            i_valid = poke; i_op = 4'd0; i_use_acc = 1'b0; i_a = W'(1); i_b = W'(1);
            for (int k = 1; k <= W; k++) begin
                check("mul_busy_ready", {d0_ready, d1_ready}, 2'b00);
                check("mul_busy_valid", {d0_valid, d1_valid}, 2'b00);
                @(negedge clk);
            end
        end
        i_valid = 1'b0;
        check("done_valid", {d0_valid, d1_valid}, 2'b11);
        check("done_ready", {d0_ready, d1_ready}, 2'b11);
        acc0 = e0.res;
        acc1 = e1.res;
    endtask

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] res0, res1;
        logic [6:0]   flags0;
        logic         ovf1;
    } vec_t;

    vec_t vecs[15];
    exp_t e0, e1;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"add_7p1",     4'd0, 4'h7, 4'h1, 4'h0, 4'h7, 7'b0110000, 1'b1};
        vecs[1]  = '{"add_m8pm1",   4'd0, 4'h8, 4'hF, 4'h0, 4'h8, 7'b1110000, 1'b1};
        vecs[2]  = '{"add_3p4",     4'd0, 4'h3, 4'h4, 4'h7, 4'h7, 7'b0000000, 1'b0};
        vecs[3]  = '{"sub_3m5",     4'd1, 4'h3, 4'h5, 4'hE, 4'hE, 7'b0001000, 1'b0};
        vecs[4]  = '{"sub_5m3",     4'd1, 4'h5, 4'h3, 4'h2, 4'h2, 7'b1000000, 1'b0};
        vecs[5]  = '{"max_m3_2",    4'd6, 4'hD, 4'h2, 4'h2, 4'h2, 7'b0000000, 1'b0};
        vecs[6]  = '{"max_2_m3",    4'd6, 4'h2, 4'hD, 4'h2, 4'h2, 7'b0000100, 1'b0};
        vecs[7]  = '{"equ_5_5",     4'd7, 4'h5, 4'h5, 4'h1, 4'h1, 7'b0000010, 1'b0};
        vecs[8]  = '{"equ_5_4",     4'd7, 4'h5, 4'h4, 4'h0, 4'h0, 7'b0010000, 1'b0};
        vecs[9]  = '{"op12",        4'd12, 4'h5, 4'h3, 4'h0, 4'h0, 7'b0010001, 1'b0};
        vecs[10] = '{"mul_3_m2",    4'd8, 4'h3, 4'hE, 4'hA, 4'hA, 7'b0001000, 1'b0};
        vecs[11] = '{"mul_m3_5",    4'd8, 4'hD, 4'h5, 4'h0, 4'h8, 7'b0110000, 1'b1};
        vecs[12] = '{"not_5",       4'd2, 4'h5, 4'h0, 4'hA, 4'hA, 7'b0001000, 1'b0};
        vecs[13] = '{"and_c_a",     4'd3, 4'hC, 4'hA, 4'h8, 4'h8, 7'b0001000, 1'b0};
        vecs[14] = '{"xor_f_5",     4'd5, 4'hF, 4'h5, 4'hA, 4'hA, 7'b0001000, 1'b0};

        i_op = '0; i_a = '0; i_b = '0; i_use_acc = 1'b0; i_valid = 1'b0; i_rst = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_ready",  {d0_ready, d1_ready}, 2'b11);
        check("rst_valid",  {d0_valid, d1_valid}, 2'b00);
        check("rst_result", {d0_result, d1_result}, '0);
        check("rst_flags",  {flags0(), flags1()}, '0);

        // Directed vectors
        foreach (vecs[i]) begin
            exec(vecs[i].op, 1'b0, vecs[i].a, vecs[i].b, 1'b0, e0, e1);
            check({vecs[i].name, "_res0"},   d0_result, vecs[i].res0);
            check({vecs[i].name, "_flags0"}, flags0(),  vecs[i].flags0);
            check({vecs[i].name, "_res1"},   d1_result, vecs[i].res1);
            check({vecs[i].name, "_ovf1"},   d1_ovf,    vecs[i].ovf1);
            @(negedge clk);
            check({vecs[i].name, "_single_pulse"}, {d0_valid, d1_valid}, 2'b00);
        end

        // Accumulator forwarding, back-to-back: 3, 6, 5
        do_reset();
        exec(4'd0, 1'b1, 4'h0, 4'h3, 1'b0, e0, e1);
        check("acc_chain_1", {d0_result, d1_result}, {4'h3, 4'h3});
        exec(4'd0, 1'b1, 4'h0, 4'h3, 1'b0, e0, e1);
        check("acc_chain_2", {d0_result, d1_result}, {4'h6, 4'h6});
        exec(4'd1, 1'b1, 4'h0, 4'h1, 1'b0, e0, e1);
        check("acc_chain_3", {d0_result, d1_result}, {4'h5, 4'h5});
        @(negedge clk);
        check("acc_chain_end", {d0_valid, d1_valid}, 2'b00);

        // Requests during MUL busy are ignored; only the MUL result appears
        exec(4'd8, 1'b0, 4'h3, 4'hE, 1'b1, e0, e1);
        check("poke_mul_res", {d0_result, d1_result}, {4'hA, 4'hA});
        @(negedge clk);
        check("poke_no_extra_valid", {d0_valid, d1_valid}, 2'b00);
        check("poke_res_held", {d0_result, d1_result}, {4'hA, 4'hA});

        // Reset in the middle of a MUL aborts it
        i_op = 4'd8; i_a = 4'h3; i_b = 4'h3; i_use_acc = 1'b0; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        acc0 = '0; acc1 = '0;
        check("mulrst_ready",  {d0_ready, d1_ready}, 2'b11);
        check("mulrst_valid",  {d0_valid, d1_valid}, 2'b00);
        check("mulrst_result", {d0_result, d1_result}, '0);
        check("mulrst_flags",  {flags0(), flags1()}, '0);
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            check("mulrst_quiet", {d0_valid, d1_valid}, 2'b00);
        end

        // Reset wins over a simultaneous request
        exec(4'd0, 1'b0, 4'h2, 4'h2, 1'b0, e0, e1);
        i_op = 4'd0; i_a = 4'h3; i_b = 4'h1; i_valid = 1'b1; i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0; i_valid = 1'b0;
        acc0 = '0; acc1 = '0;
        check("rstvld_result", {d0_result, d1_result}, '0);
        @(negedge clk);
        check("rstvld_no_accept", {d0_valid, d1_valid}, 2'b00);

        // Randomized run against the reference model
        for (int n = 0; n < 300; n++) begin
            logic [3:0]   rop;
            logic         ruse;
            logic [W-1:0] ra, rb;
            rop  = ($urandom_range(0, 7) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            ruse = 1'($urandom);
            ra   = W'($urandom);
            rb   = W'($urandom);
            exec(rop, ruse, ra, rb, 1'($urandom), e0, e1);
            check("rand_res0",   d0_result, e0.res);
            check("rand_flags0", flags0(),  e0.flags);
            check("rand_res1",   d1_result, e1.res);
            check("rand_flags1", flags1(),  e1.flags);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor of the 4-bit combinational ALU. Accepts one operation per valid/ready handshake, computes on a WIDTH-bit signed datapath, and adds an accumulator operand, a selectable overflow policy (zero or saturate) and a multi-cycle signed multiply. Result and flags are registered and held for the display/LED stage downstream.

## Interface
- WIDTH, 4: operand/result width in bits (≥2).
- SAT_MODE, 0: overflow policy for ADD/SUB/MUL; 0 = force result to 0, 1 = saturate to signed max/min.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  operation request.
- o_ready  out  1  block can accept; high only in IDLE.
- i_op  in  4  opcode (see Operation).
- i_use_acc  in  1  1: operand A = accumulator, 0: operand A = i_a.
- i_a, i_b  in  WIDTH  signed operands.
- o_valid  out  1  one-cycle pulse, result/flags just updated.
- o_result  out  WIDTH  registered result, held until next completion.
- o_carry, o_overflow, o_zero, o_neg, o_max, o_equ, o_err  out  1 each  registered flags, held with o_result.

## Operation
- Accept = i_valid & o_ready at a rising edge. A, B, op, use_acc latched at accept; later input changes have no effect.
- Opcodes (A, B signed two's complement):
  - 0 ADD: A+B; carry = carry-out; overflow = signed overflow.
  - 1 SUB: A+~B+1; carry = carry-out (1 = no borrow); overflow = signed overflow.
  - 2 NOT: ~A. 3 AND. 4 OR. 5 XOR.
  - 6 MAX: result = signed max(A,B); o_max = (A > B signed).
  - 7 EQU: result = zero-extended (A==B); o_equ = (A==B).
  - 8 MUL: signed A×B, low WIDTH bits; overflow = full 2·WIDTH product not equal to sign-extension of its low WIDTH bits. Multi-cycle.
  - 9–15: reserved; result 0, o_err = 1, all other flags 0.
- Flags not defined for an op are 0 (carry/overflow only for ADD/SUB/MUL; o_max only op 6; o_equ only op 7).
- Overflow policy, when overflow=1: SAT_MODE=0 → result 0; SAT_MODE=1 → 0111..1 if true result positive, 1000..0 if negative. o_overflow stays 1.
- o_zero = (final result == 0); o_neg = final result MSB; both evaluated after overflow policy.
- Accumulator: WIDTH-bit register, loaded with final o_result at every completion (including reserved ops).
- FSM: IDLE → (accept op 8) → MUL → (WIDTH iterations done) → IDLE. Non-MUL ops complete from IDLE without leaving it.

## Timing
- Reset: state IDLE, o_ready 1, o_valid 0, o_result 0, all flags 0, accumulator 0.
- Non-MUL: accept at edge N → o_valid high cycle N+1 with result/flags. o_ready stays high; back-to-back accepts every cycle allowed.
- MUL: accept at edge N → o_ready low cycles N+1..N+WIDTH; o_valid pulses in cycle N+WIDTH+1 and o_ready returns high the same cycle.
- Accumulator forwarding: an op accepted in the cycle o_valid is high with i_use_acc=1 sees the just-completed result (no hazard bubble).
- i_valid while o_ready=0: ignored, not queued.
- i_rst during MUL: abort, return to reset values; no o_valid, no flag/acc update.
- i_rst and i_valid same edge: reset wins, nothing accepted.
- o_valid never high for two consecutive cycles from one accept.

## Test plan
- WIDTH=4, SAT_MODE=0: ADD 7+1 → o_result 0000, o_overflow 1, o_zero 1; SAT_MODE=1 same stimulus → 0111, o_overflow 1, o_zero 0; ADD −8+−1 → 1000.
- SUB 3−5 → 1110, o_carry 0, o_neg 1, o_overflow 0; SUB 5−3 → 0010, o_carry 1.
- MUL accepted at edge N: 3×(−2) → 1010, overflow 0, o_valid in cycle N+5, o_ready low N+1..N+4; (−3)×5 SAT_MODE=1 → 1000, overflow 1.
- Accumulator chain back-to-back: after reset, ADD(acc,3), ADD(acc,3), SUB(acc,1) with i_use_acc=1 on consecutive cycles → o_result 3, 6, 5 on consecutive o_valid pulses.
- Assert i_valid with ADD during MUL busy cycles → ignored, only MUL result emitted; i_rst at cycle N+2 of MUL → no o_valid, outputs 0, o_ready 1 next cycle.
- MAX(−3,2) → 0010, o_max 0; MAX(2,−3) → 0010, o_max 1; EQU(5,5) → 0001, o_equ 1; op 12 → 0000, o_err 1.
